// File: rtl/apu_regdump_recorder_pkg.sv
// Shared definitions for the APU register-dump recorder.
// Holds the APU address window, the log-entry field layout and the
// serializer state encoding used by the recorder and its FIFO.
package apu_regdump_recorder_pkg;

  localparam logic [15:0] APU_BASE    = 16'h4000;
  localparam int          APU_MATCH_W = 11;

  localparam int WORD_W      = 32;
  localparam int ENTRY_W     = 2 * WORD_W;
  localparam int REG_LSB     = 0;
  localparam int REG_W       = 5;
  localparam int RD_FLAG_BIT = 7;
  localparam int VAL_LSB     = 8;
  localparam int VAL_W       = 8;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_W0   = 2'd1,
    SER_W1   = 2'd2
  } ser_state_t;

  function automatic logic is_apu_access(input logic [15:0] addr);
    return addr[15:16-APU_MATCH_W] == APU_BASE[15:16-APU_MATCH_W];
  endfunction

endpackage

// File: rtl/apu_regdump_recorder_if.sv
// Log output stream of the APU register-dump recorder.
// Ports: log_valid/log_word driven by the recorder (master),
//        log_ready driven by the sink (slave).
interface apu_regdump_recorder_if;
  import apu_regdump_recorder_pkg::*;

  logic              log_valid;
  logic              log_ready;
  logic [WORD_W-1:0] log_word;

  modport master (output log_valid, output log_word, input log_ready);
  modport slave  (input log_valid, input log_word, output log_ready);

endinterface

// File: rtl/apu_regdump_fifo.sv
// Synchronous FIFO holding complete 64-bit log entries.
// Ports: clk/rst_n (async active-low), push/wdata, pop/rdata (head, valid
// while !empty), full, empty, count (occupancy, 0..DEPTH).
// Push while full and pop while empty are ignored.
module apu_regdump_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rdata    = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/apu_regdump_recorder.sv
// APU register-dump recorder.
// Sniffs the CPU bus each PHI0 cycle; every access to 0x4000..0x401F is
// logged as a 64-bit entry {cycles since previous logged access, access
// descriptor} and streamed out as two 32-bit words over a valid/ready port.
// Ports: PHI0 (clock), n_RES (async active-low reset), enable, RnW/A/D
// (sniffed bus), log (stream master), overflow (sticky drop flag),
// drop_cnt (saturating count of dropped accesses).
module apu_regdump_recorder
  import apu_regdump_recorder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   PHI0,
  input  logic                   n_RES,
  input  logic                   enable,
  input  logic                   RnW,
  input  logic [15:0]            A,
  input  logic [7:0]             D,
  apu_regdump_recorder_if.master log,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic               apu_hit, room, log_hit, drop_hit;
  logic [31:0]        delta_q, delta_d, delta_inc;
  logic [WORD_W-1:0]  word1_d;
  logic               vld_p0_q, vld_p0_d;
  logic [ENTRY_W-1:0] entry_p0_q, entry_p0_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  ser_state_t         state_q, state_d;

  // Stage p0: bus sample into the capture register.
  // The captured entry still owns a slot, so room counts it with the FIFO.
  always_comb begin
    apu_hit   = is_apu_access(A);
    room      = !fifo_full && !(vld_p0_q && fifo_count == CW'(FIFO_DEPTH - 1));
    log_hit   = enable && apu_hit && room;
    drop_hit  = enable && apu_hit && !room;
    delta_inc = sat_inc32(delta_q);

    word1_d                        = '0;
    word1_d[REG_LSB +: REG_W]      = A[REG_W-1:0];
    word1_d[RD_FLAG_BIT]           = RnW;
    word1_d[VAL_LSB +: VAL_W]      = RnW ? 8'h00 : D;

    delta_d    = log_hit ? 32'd0 : delta_inc;
    vld_p0_d   = log_hit;
    entry_p0_d = log_hit ? {delta_inc, word1_d} : entry_p0_q;
    overflow_d = overflow_q || drop_hit;
    drop_cnt_d = drop_hit ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  // Stage p1: entry buffer.
  apu_regdump_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (PHI0),
    .rst_n (n_RES),
    .push  (vld_p0_q),
    .wdata (entry_p0_q),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p2: serializer, head entry sent as word0 then word1.
  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    log.log_valid = 1'b0;
    log.log_word  = '0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          state_d = SER_W0;
        end
      end
      SER_W0: begin
        log.log_valid = 1'b1;
        log.log_word  = fifo_head[ENTRY_W-1 -: WORD_W];
        if (log.log_ready) begin
          state_d = SER_W1;
        end
      end
      SER_W1: begin
        log.log_valid = 1'b1;
        log.log_word  = fifo_head[WORD_W-1:0];
        if (log.log_ready) begin
          fifo_pop = 1'b1;
          // Another entry is either already queued or being pushed this edge.
          state_d  = (fifo_count > CW'(1) || vld_p0_q) ? SER_W0 : SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      delta_q    <= '0;
      vld_p0_q   <= 1'b0;
      entry_p0_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= SER_IDLE;
    end else begin
      delta_q    <= delta_d;
      vld_p0_q   <= vld_p0_d;
      entry_p0_q <= entry_p0_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_apu_regdump_recorder.sv
// Self-checking bench for apu_regdump_recorder.
// A reference model keeps the expected output word stream as a queue, the
// cycle count since the last logged access and the drop count; directed
// scenarios additionally compare the emitted words against fixed values.
module tb_apu_regdump_recorder;
  localparam int DEPTH = 8;

  logic        PHI0;
  logic        n_RES;
  logic        enable;
  logic        RnW;
  logic [15:0] A;
  logic [7:0]  D;
  logic        overflow;
  logic [15:0] drop_cnt;

  apu_regdump_recorder_if lg();

  apu_regdump_recorder #(.FIFO_DEPTH(DEPTH)) dut (
    .PHI0     (PHI0),
    .n_RES    (n_RES),
    .enable   (enable),
    .RnW      (RnW),
    .A        (A),
    .D        (D),
    .log      (lg.master),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  logic [31:0] m_cnt;
  int          m_drops;
  int          nvec;
  int          nfail;
  logic        stall_prev;
  logic [31:0] word_prev;

  // One CPU cycle: entered just after a falling edge, returns after the next.
  task automatic cycle(input logic en, input logic rnw, input logic [15:0] a,
                       input logic [7:0] d, input logic rdy);
    logic        acc;
    int          pending;
    logic [31:0] dl;
    enable = en; RnW = rnw; A = a; D = d; lg.log_ready = rdy;
    #1;
    if (stall_prev) begin
      nvec++;
      if (lg.log_valid !== 1'b1 || lg.log_word !== word_prev) begin
        nfail++;
        $display("FAIL stall_hold: valid=%b word=%h, required valid=1 word=%h",
                 lg.log_valid, lg.log_word, word_prev);
      end
    end
    nvec++;
    if (overflow !== (m_drops != 0) || drop_cnt !== 16'(m_drops)) begin
      nfail++;
      $display("FAIL drop_state: overflow=%b drop_cnt=%0d, required overflow=%b drop_cnt=%0d",
               overflow, drop_cnt, (m_drops != 0), m_drops);
    end
    acc = (lg.log_valid === 1'b1) && rdy;
    if (acc) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL spurious_word: got %h, required no word", lg.log_word);
      end else if (lg.log_word !== exp_q[0]) begin
        nfail++;
        $display("FAIL word: got %h, required %h", lg.log_word, exp_q[0]);
      end
      seen_q.push_back(lg.log_word);
    end
    // Entries occupy a slot until their second word is accepted.
    pending = (exp_q.size() + 1) / 2;
    if (acc && exp_q.size() != 0) void'(exp_q.pop_front());
    dl = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
    if (en && a >= 16'h4000 && a <= 16'h401F) begin
      if (pending < DEPTH) begin
        exp_q.push_back(dl);
        exp_q.push_back({16'h0000, (rnw ? 8'h00 : d), rnw, 2'b00, a[4:0]});
        m_cnt = 32'd0;
      end else begin
        if (m_drops < 65535) m_drops++;
        m_cnt = dl;
      end
    end else begin
      m_cnt = dl;
    end
    stall_prev = (lg.log_valid === 1'b1) && !rdy;
    word_prev  = lg.log_word;
    @(negedge PHI0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b1, 1'b1, 16'h0000, 8'h00, rdy);
  endtask

  task automatic do_reset();
    #2;
    n_RES = 1'b0;
    #1;
    exp_q.delete();
    seen_q.delete();
    m_cnt = 32'd0; m_drops = 0; stall_prev = 1'b0; word_prev = '0;
    enable = 1'b0; RnW = 1'b1; A = 16'h0000; D = 8'h00; lg.log_ready = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge PHI0);
    n_RES = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || lg.log_valid === 1'b1) && n < 200) begin
      idle(1'b1);
      n++;
    end
    nvec++;
    if (exp_q.size() != 0 || lg.log_valid !== 1'b0) begin
      nfail++;
      $display("FAIL drain: %0d words outstanding valid=%b, required 0 and 0",
               exp_q.size(), lg.log_valid);
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] req);
    nvec++;
    if (idx >= seen_q.size()) begin
      nfail++;
      $display("FAIL %s: word %0d missing, required %h", name, idx, req);
    end else if (seen_q[idx] !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, seen_q[idx], req);
    end
  endtask

  task automatic check_count(input string name, input int req);
    nvec++;
    if (seen_q.size() != req) begin
      nfail++;
      $display("FAIL %s: %0d words, required %0d", name, seen_q.size(), req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    nvec += 4;
    if (lg.log_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b, required 0", lg.log_valid); end
    if (lg.log_word !== 32'h0) begin nfail++; $display("FAIL rst_word: got %h, required 0", lg.log_word); end
    if (overflow !== 1'b0) begin nfail++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    if (drop_cnt !== 16'h0) begin nfail++; $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); end
    release_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_count("rst_no_output", 0);
  endtask

  task automatic test_first_write();
    do_reset(); release_reset();
    for (int i = 1; i <= 4; i++) idle(1'b1);
    cycle(1'b1, 1'b0, 16'h4015, 8'h3F, 1'b1);
    drain();
    check_count("first_write_count", 2);
    check_word("first_write_w0", 0, 32'h0000_0005);
    check_word("first_write_w1", 1, 32'h0000_3F15);
  endtask

  task automatic test_read_pair();
    do_reset(); release_reset();
    for (int i = 1; i <= 9; i++) idle(1'b1);
    cycle(1'b1, 1'b1, 16'h4015, 8'hAA, 1'b1);
    cycle(1'b1, 1'b1, 16'h4015, 8'hAA, 1'b1);
    drain();
    check_count("read_pair_count", 4);
    check_word("read_pair_first_w0", 0, 32'h0000_000A);
    check_word("read_pair_w0", 2, 32'h0000_0001);
    check_word("read_pair_w1", 3, 32'h0000_0095);
  endtask

  task automatic test_overflow();
    do_reset(); release_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 16'h4000 + 16'(i), 8'(i + 1), 1'b0);
    nvec++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      nfail++;
      $display("FAIL overflow_flag: overflow=%b drop_cnt=%0d, required 1 and 1", overflow, drop_cnt);
    end
    idle(1'b0); idle(1'b0);
    drain();
    check_count("overflow_count", 16);
    for (int i = 0; i < 8; i++) begin
      check_word("overflow_w0", 2 * i, 32'd1);
      check_word("overflow_w1", 2 * i + 1, {16'h0000, 8'(i + 1), 3'b000, 5'(i)});
    end
  endtask

  task automatic test_non_apu();
    do_reset(); release_reset();
    cycle(1'b1, 1'b0, 16'h4020, 8'h12, 1'b1);
    cycle(1'b1, 1'b1, 16'h3FFF, 8'h34, 1'b1);
    cycle(1'b1, 1'b0, 16'h4000, 8'h5A, 1'b1);
    drain();
    check_count("non_apu_count", 2);
    check_word("non_apu_w0", 0, 32'h0000_0003);
    check_word("non_apu_w1", 1, 32'h0000_5A00);
  endtask

  task automatic test_enable_off();
    do_reset(); release_reset();
    cycle(1'b0, 1'b0, 16'h4001, 8'h99, 1'b1);
    cycle(1'b1, 1'b0, 16'h4002, 8'h11, 1'b1);
    drain();
    check_count("enable_off_count", 2);
    check_word("enable_off_w0", 0, 32'h0000_0002);
    check_word("enable_off_w1", 1, 32'h0000_1102);
  endtask

  task automatic test_ready_toggle();
    do_reset(); release_reset();
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0)
        cycle(1'b1, 1'($urandom), 16'h4000 + 16'($urandom_range(0, 31)), 8'($urandom), 1'(c));
      else
        idle(1'(c));
    end
    drain();
  endtask

  task automatic test_reset_w1();
    int n;
    do_reset(); release_reset();
    cycle(1'b1, 1'b0, 16'h401F, 8'hC3, 1'b0);
    n = 0;
    while (lg.log_valid !== 1'b1 && n < 10) begin idle(1'b0); n++; end
    idle(1'b1);
    nvec++;
    if (lg.log_valid !== 1'b1) begin
      nfail++;
      $display("FAIL w1_reached: valid=%b, required 1", lg.log_valid);
    end
    do_reset();
    nvec += 2;
    if (lg.log_valid !== 1'b0) begin nfail++; $display("FAIL w1_reset_valid: got %b, required 0", lg.log_valid); end
    if (lg.log_word !== 32'h0) begin nfail++; $display("FAIL w1_reset_word: got %h, required 0", lg.log_word); end
    release_reset();
    idle(1'b1); idle(1'b1);
    cycle(1'b1, 1'b0, 16'h4008, 8'h77, 1'b1);
    drain();
    check_count("w1_after_count", 2);
    check_word("w1_after_w0", 0, 32'h0000_0003);
    check_word("w1_after_w1", 1, 32'h0000_7708);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        rdy;
    do_reset(); release_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: a = 16'h4000 + 16'($urandom_range(0, 31));
        5:             a = 16'h4020 + 16'($urandom_range(0, 31));
        6:             a = 16'h3FE0 + 16'($urandom_range(0, 31));
        default:       a = 16'($urandom);
      endcase
      if ((c / 300) % 2 == 0) rdy = ($urandom_range(0, 9) < 2);
      else                    rdy = ($urandom_range(0, 9) < 8);
      cycle(($urandom_range(0, 9) != 0), 1'($urandom), a, 8'($urandom), rdy);
    end
    drain();
  endtask

  initial begin
    nvec = 0; nfail = 0;
    n_RES = 1'b1; enable = 1'b0; RnW = 1'b1; A = 16'h0000; D = 8'h00;
    lg.log_ready = 1'b0;
    stall_prev = 1'b0; word_prev = '0; m_cnt = 32'd0; m_drops = 0;
    #1 n_RES = 1'b0;
    @(negedge PHI0);
    test_reset();
    test_first_write();
    test_read_pair();
    test_overflow();
    test_reset();
    test_non_apu();
    test_enable_off();
    test_ready_toggle();
    test_reset_w1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
